// File: rtl/wb_traffic_gen.sv
// Wishbone burst traffic generator: writes a seeded address pattern in bursts,
// reads the same range back, and reports mismatches, timeouts and completion.
module wb_traffic_gen #(
   parameter int APP_AW  = 26,
   parameter int TMO_CYC = 255
) (
   input  logic              sys_clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              sdr_init_done,
   input  logic [APP_AW-1:0] cfg_base_addr,
   input  logic [3:0]        cfg_burst_len,
   input  logic [7:0]        cfg_num_bursts,
   input  logic [31:0]       cfg_seed,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [APP_AW-1:0] wb_addr_o,
   output logic [3:0]        wb_sel_o,
   output logic [31:0]       wb_dat_o,
   output logic [2:0]        wb_cti_o,
   input  logic              wb_ack_i,
   input  logic [31:0]       wb_dat_i,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [15:0]       err_cnt,
   output logic [APP_AW-1:0] first_err_addr,
   output logic [2:0]        dbg_state
);

   // Handshake: a beat completes on any cycle where wb_stb_o and wb_ack_i are
   // both high; an ack seen while wb_stb_o is low has no effect.

   localparam int TMO_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WR_BURST = 3'd1,
      S_WR_GAP   = 3'd2,
      S_RD_BURST = 3'd3,
      S_RD_GAP   = 3'd4,
      S_DONE     = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic [APP_AW-1:0] base_q, base_d;
   logic [3:0]        len_q, len_d;
   logic [7:0]        nb_q, nb_d;
   logic [31:0]       seed_q, seed_d;
   logic [APP_AW-1:0] addr_q, addr_d;
   logic [3:0]        beat_q, beat_d;
   logic [7:0]        burst_q, burst_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [15:0]       err_cnt_q, err_cnt_d;
   logic [APP_AW-1:0] first_err_q, first_err_d;
   logic              timeout_q, timeout_d;

   logic              in_burst;
   logic              beat_last;
   logic [31:0]       pattern;

   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         len_q       <= '0;
         nb_q        <= '0;
         seed_q      <= '0;
         addr_q      <= '0;
         beat_q      <= '0;
         burst_q     <= '0;
         tmo_q       <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         nb_q        <= nb_d;
         seed_q      <= seed_d;
         addr_q      <= addr_d;
         beat_q      <= beat_d;
         burst_q     <= burst_d;
         tmo_q       <= tmo_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         timeout_q   <= timeout_d;
      end
   end

   assign in_burst  = (state_q == S_WR_BURST) || (state_q == S_RD_BURST);
   assign beat_last = (beat_q == (len_q - 4'd1));
   assign pattern   = seed_q ^ 32'(addr_q);

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      len_d       = len_q;
      nb_d        = nb_q;
      seed_d      = seed_q;
      addr_d      = addr_q;
      beat_d      = beat_q;
      burst_d     = burst_q;
      tmo_d       = tmo_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      timeout_d   = timeout_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start && sdr_init_done) begin
               base_d      = {cfg_base_addr[APP_AW-1:2], 2'b00};
               addr_d      = {cfg_base_addr[APP_AW-1:2], 2'b00};
               len_d       = (cfg_burst_len == 4'd0) ? 4'd1 :
                             (cfg_burst_len > 4'd8)  ? 4'd8 : cfg_burst_len;
               nb_d        = cfg_num_bursts;
               seed_d      = cfg_seed;
               beat_d      = '0;
               burst_d     = '0;
               tmo_d       = '0;
               err_cnt_d   = '0;
               first_err_d = '0;
               timeout_d   = 1'b0;
               state_d     = (cfg_num_bursts == 8'd0) ? S_DONE : S_WR_BURST;
            end
         end
         S_WR_BURST, S_RD_BURST: begin
            if (wb_ack_i) begin
               tmo_d  = '0;
               addr_d = addr_q + APP_AW'(4);
               if ((state_q == S_RD_BURST) && (wb_dat_i != pattern)) begin
                  // err_cnt of zero doubles as "no mismatch captured yet"
                  if (err_cnt_q == 16'd0) begin
                     first_err_d = addr_q;
                  end
                  if (err_cnt_q != 16'hFFFF) begin
                     err_cnt_d = err_cnt_q + 16'd1;
                  end
               end
               if (beat_last) begin
                  beat_d  = '0;
                  burst_d = burst_q + 8'd1;
                  state_d = (state_q == S_WR_BURST) ? S_WR_GAP : S_RD_GAP;
               end else begin
                  beat_d = beat_q + 4'd1;
               end
            end else if (tmo_q == TMO_LAST) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_WR_GAP: begin
            // Read phase replays the write addresses from the base
            if (burst_q == nb_q) begin
               burst_d = '0;
               addr_d  = base_q;
               state_d = S_RD_BURST;
            end else begin
               state_d = S_WR_BURST;
            end
         end
         S_RD_GAP: begin
            state_d = (burst_q == nb_q) ? S_DONE : S_RD_BURST;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign wb_cyc_o       = in_burst;
   assign wb_stb_o       = in_burst;
   assign wb_we_o        = (state_q == S_WR_BURST);
   assign wb_addr_o      = addr_q;
   assign wb_sel_o       = 4'hF;
   assign wb_dat_o       = (state_q == S_WR_BURST) ? pattern : 32'h0;
   assign wb_cti_o       = !in_burst ? 3'b000 : (beat_last ? 3'b111 : 3'b010);
   assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done           = (state_q == S_DONE);
   assign timeout        = timeout_q;
   assign err_cnt        = err_cnt_q;
   assign first_err_addr = first_err_q;
   assign dbg_state      = state_q;

endmodule
